mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the CPU's single-port memory between instruction fetch and load/store data access. It sits between the fetch stage, the load/store path (driven by the `mem_read`/`mem_write` control decode), and the unified memory. It serialises requests through a small FSM. It registers all memory-side outputs and returns a one-cycle acknowledge with read data to the winning requester.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants tolerated while fetch waits (used only with starvation guard)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  one-cycle pulse: fetch complete, `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched word; held until next fetch completion
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_ack`  out  1  one-cycle pulse: data access complete
- `d_rdata`  out  DATA_W  load data; updated only on load completion
- `mem_req`  out  1  memory access active
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid when `mem_ready`=1
- `mem_ready`  in  1  memory completes current access this cycle

## Operation
- States: IDLE, BUSY_I, BUSY_D, ACK_I, ACK_D.
- IDLE: arbitration happens only here.
  - `d_req`=1 → latch `d_we`/`d_addr`/`d_wdata` into `mem_*` regs, `mem_req`←1, go to BUSY_D.
  - Else `if_req`=1 → `mem_addr`←`if_addr`, `mem_we`←0, `mem_req`←1, go to BUSY_I.
  - Neither → stay in IDLE.
- Default priority: data over fetch.
- BUSY_x: `mem_*` held constant.
  - `mem_ready`=1 → `mem_req`←0, `mem_we`←0, go to ACK_x.
  - For BUSY_I, also `if_rdata`←`mem_rdata`.
  - For BUSY_D with a load, also `d_rdata`←`mem_rdata`.
- ACK_x: `x_ack`=1 for exactly this cycle, then go to IDLE unconditionally.
  - A request still high in the following IDLE cycle is treated as a new request. Requesters must deassert on seeing ack, or present the next access.
- `mem_ready` outside BUSY_x is ignored.
- Stores leave `d_rdata` unchanged.
- Never more than one outstanding memory access. `if_ack` and `d_ack` are never high together.

## Timing
- All outputs registered.
- Reset values: state IDLE; `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `if_ack`=0, `d_ack`=0, `if_rdata`=0, `d_rdata`=0; starvation counter 0.
- Request seen in IDLE at cycle t → `mem_req`=1 at t+1.
- `mem_ready` at cycle k ≥ t+1 → ack at k+1 → IDLE at k+2.
- Minimum request-to-ack latency is 2 cycles; minimum spacing between transactions is 3 cycles.
- Both requests arriving in the same IDLE cycle: data wins. Fetch waits, with `if_req` held, and is granted at the next IDLE unless data requests again.
- Reset asserted mid-transaction: next cycle all outputs are at reset values and the in-flight access is abandoned, with no ack. Memory must tolerate `mem_req` dropping before `mem_ready`.
- Requester changing fields while its request is pending but ungranted: the values sampled at grant are used.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: a 3-bit (min) counter of consecutive data grants made while `if_req`=1.
  - The counter resets on any fetch grant, or on a data grant with `if_req`=0.
  - When the count equals `STARVE_MAX` and both request in IDLE, fetch is granted and the counter clears.
- Not defined: strict data priority, no counter logic, and `STARVE_MAX` is unused.

## Test plan
- Reset, idle: after `rst` pulse, all outputs 0. Then `if_req`=1, `if_addr`=0x10, `mem_ready` tied 1, `mem_rdata`=0x00500093 → `mem_req` at t+1, `if_ack` and `if_rdata`=0x00500093 at t+2.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `mem_ready` delayed 3 cycles → `mem_we`=1 and fields held 4 cycles, `d_ack` one cycle after `mem_ready`, `d_rdata` unchanged.
- Simultaneous: `if_req` and `d_req` raised together → data granted first. Fetch is granted in the IDLE after `d_ack` and acked later; the two acks are never coincident.
- Starvation (`ARB_STARVE_GUARD_EN`, `STARVE_MAX`=4): `if_req` held high, `d_req` re-asserted every IDLE → exactly 4 data grants, then a fetch grant, then data resumes.
- Reset mid-op: `rst` asserted while in BUSY_D with `mem_ready`=0 → next cycle `mem_req`=0, no `d_ack` ever issued, and state returns to IDLE.
- Back-to-back loads: two consecutive load requests to 0x200 and 0x204 with `mem_ready`=1 → acks spaced 3 cycles apart, with `d_rdata` updated on each.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and load/store data access. Arbitration happens only in IDLE. Data
// normally wins over fetch, and at most one memory access is in flight.
// Every memory-side output, ack and read-data port comes from a register.
// Optional feature macro: ARB_STARVE_GUARD_EN. When it is defined, fetch is
// forced through after STARVE_MAX consecutive data grants made while fetch
// was waiting.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    ACK_I  = 3'd3,
    ACK_D  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                fetch_turn;
  logic                grant_d;
  logic                grant_i;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W =
    ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  logic [CNT_W-1:0] starve_q, starve_d;

  assign fetch_turn = if_req && (starve_q == CNT_W'(STARVE_MAX));

  // Count consecutive data grants taken while fetch is waiting.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (grant_d) begin
        starve_d = if_req ? starve_q + 1'b1 : '0;
      end else if (grant_i) begin
        starve_d = '0;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign fetch_turn = 1'b0;
`endif

  assign grant_d = d_req && !fetch_turn;
  assign grant_i = if_req && !grant_d;

  // Next-state and registered-output logic: grant in IDLE, hold while busy,
  // capture read data and raise the ack on mem_ready.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          state_d     = BUSY_D;
        end else if (grant_i) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          state_d    = BUSY_I;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mem_rdata;
          if_ack_d   = 1'b1;
          state_d    = ACK_I;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) d_rdata_d = mem_rdata;
          d_ack_d   = 1'b1;
          state_d   = ACK_D;
        end
      end
      ACK_I, ACK_D: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model and a word memory.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_ack, d_req, d_we, d_ack;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ready;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_ir, exp_dr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = 32'hFFFF_FFFF; mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({mem_req, mem_we, if_ack, d_ack, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%0h exp=0",
               {mem_req, mem_we, if_ack, d_ack, mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({mem_req, if_ack, d_ack} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got=%0b exp=000", {mem_req, if_ack, d_ack});
    end
    exp_ir = '0; exp_dr = '0;
  endtask

  task automatic test_fetch_basic();
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, if_ack} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin
      failures++;
      $display("FAIL fetch_grant got=%0h exp=%0h", {mem_req, mem_we, mem_addr, if_ack},
               {1'b1, 1'b0, 32'h10, 1'b0});
    end
    tick();
    exp_ir = 32'h0050_0093;
    checks++;
    if ({if_ack, d_ack, mem_req, if_rdata} !== {3'b100, exp_ir}) begin
      failures++;
      $display("FAIL fetch_ack got=%0h exp=%0h", {if_ack, d_ack, mem_req, if_rdata},
               {3'b100, exp_ir});
    end
    if_req = 1'b0;
    tick();
    checks++;
    if ({if_ack, mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_ack_pulse got=%0b exp=00", {if_ack, mem_req});
    end
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL ready_ignored_idle got=%0b exp=0", mem_req);
    end
  endtask

  task automatic test_store();
    mem_ready = 1'b0; mem_rdata = 32'h1234_5678;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, d_ack} !==
          {2'b11, 32'h100, 32'hDEAD_BEEF, 1'b0}) begin
        failures++;
        $display("FAIL store_hold[%0d] got=%0h exp=%0h", i,
                 {mem_req, mem_we, mem_addr, mem_wdata, d_ack},
                 {2'b11, 32'h100, 32'hDEAD_BEEF, 1'b0});
      end
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if ({d_ack, if_ack, mem_req, mem_we, d_rdata} !== {4'b1000, exp_dr}) begin
      failures++;
      $display("FAIL store_ack got=%0h exp=%0h", {d_ack, if_ack, mem_req, mem_we, d_rdata},
               {4'b1000, exp_dr});
    end
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    tick();
    checks++;
    if (d_ack !== 1'b0) begin
      failures++;
      $display("FAIL store_ack_pulse got=%0b exp=0", d_ack);
    end
  endtask

  task automatic test_simultaneous();
    mem_ready = 1'b1; mem_rdata = 32'h0000_1111;
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h40}) begin
      failures++;
      $display("FAIL simul_data_first got=%0h exp=%0h", {mem_req, mem_we, mem_addr},
               {2'b10, 32'h40});
    end
    tick();
    exp_dr = 32'h0000_1111;
    checks++;
    if ({d_ack, if_ack, d_rdata} !== {2'b10, exp_dr}) begin
      failures++;
      $display("FAIL simul_d_ack got=%0h exp=%0h", {d_ack, if_ack, d_rdata}, {2'b10, exp_dr});
    end
    d_req = 1'b0; mem_rdata = 32'h0000_2222;
    tick();
    checks++;
    if ({d_ack, if_ack, mem_req} !== 3'b000) begin
      failures++;
      $display("FAIL simul_gap got=%0b exp=000", {d_ack, if_ack, mem_req});
    end
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h20}) begin
      failures++;
      $display("FAIL simul_fetch_grant got=%0h exp=%0h", {mem_req, mem_we, mem_addr},
               {2'b10, 32'h20});
    end
    tick();
    exp_ir = 32'h0000_2222;
    checks++;
    if ({if_ack, d_ack, if_rdata} !== {2'b10, exp_ir}) begin
      failures++;
      $display("FAIL simul_i_ack got=%0h exp=%0h", {if_ack, d_ack, if_rdata}, {2'b10, exp_ir});
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_rdata = 32'hA5A5_0200;
    tick();
    tick();
    exp_dr = 32'hA5A5_0200;
    checks++;
    if ({d_ack, d_rdata} !== {1'b1, exp_dr}) begin
      failures++;
      $display("FAIL b2b_first got=%0h exp=%0h", {d_ack, d_rdata}, {1'b1, exp_dr});
    end
    d_addr = 32'h204; mem_rdata = 32'h5A5A_0204;
    tick();
    tick();
    checks++;
    if ({d_ack, mem_req, mem_addr} !== {2'b01, 32'h204}) begin
      failures++;
      $display("FAIL b2b_second_grant got=%0h exp=%0h", {d_ack, mem_req, mem_addr},
               {2'b01, 32'h204});
    end
    tick();
    exp_dr = 32'h5A5A_0204;
    checks++;
    if ({d_ack, d_rdata} !== {1'b1, exp_dr}) begin
      failures++;
      $display("FAIL b2b_second got=%0h exp=%0h", {d_ack, d_rdata}, {1'b1, exp_dr});
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int   ng = 0;
    logic prev;
    logic isd [6];
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    if_req = 1'b1; if_addr = 32'h50;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    prev = mem_req;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      tick();
      if (mem_req && !prev) begin
        isd[ng] = (mem_addr == 32'h60);
        ng++;
      end
      prev = mem_req;
    end
    checks++;
    if (ng != 6) begin
      failures++;
      $display("FAIL starve_grant_count got=%0d exp=6", ng);
    end
    for (int i = 0; i < ng; i++) begin
      logic e;
`ifdef ARB_STARVE_GUARD_EN
      e = (i != int'(SMAX));
`else
      e = 1'b1;
`endif
      checks++;
      if (isd[i] !== e) begin
        failures++;
        $display("FAIL starve_grant[%0d] data_got=%0b data_exp=%0b", i, isd[i], e);
      end
    end
    d_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    if_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_reset_midop();
    logic saw_ack = 1'b0;
    logic saw_req = 1'b0;
    mem_ready = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_rdata = 32'h3333_3333;
    tick();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin
      failures++;
      $display("FAIL midop_grant got=%0h exp=%0h", {mem_req, mem_addr}, {1'b1, 32'h300});
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({mem_req, mem_we, if_ack, d_ack, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      failures++;
      $display("FAIL midop_reset got=%0h exp=0",
               {mem_req, mem_we, if_ack, d_ack, mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    rst = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    exp_ir = '0; exp_dr = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      saw_ack |= d_ack;
      saw_req |= mem_req;
    end
    checks++;
    if ({saw_ack, saw_req} !== 2'b00) begin
      failures++;
      $display("FAIL midop_abandon ack_req_got=%0b exp=00", {saw_ack, saw_req});
    end
    if_req = 1'b1; if_addr = 32'h44; mem_rdata = 32'h0000_CAFE;
    tick();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h44}) begin
      failures++;
      $display("FAIL midop_back_idle got=%0h exp=%0h", {mem_req, mem_addr}, {1'b1, 32'h44});
    end
    tick();
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] rmem [16];
    int            m_st, cnt, rv;
    logic          cur_d, cur_we, gd, gi, own_i, own_d, ack_i, ack_d;
    logic [AW-1:0] cur_addr, a;
    logic [DW-1:0] cur_wd, e_ir, e_dr;
    logic          s_ir, s_dr, s_dwe, s_rdy;
    logic [AW-1:0] s_ia, s_da;
    logic [DW-1:0] s_dwd;
    for (int i = 0; i < 16; i++) rmem[i] = $urandom;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick();
    rst = 1'b0;
    m_st = 0; cnt = 0; cur_d = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_wd = '0;
    e_ir = '0; e_dr = '0;
    s_ir = 1'b0; s_dr = 1'b0; s_dwe = 1'b0; s_rdy = 1'b0; s_ia = '0; s_da = '0; s_dwd = '0;
    for (int c = 0; c < 800; c++) begin
      tick();
      // Reference: 0 = free, 1 = access in flight, 2 = acknowledging.
      case (m_st)
        0: begin
          gd = s_dr;
`ifdef ARB_STARVE_GUARD_EN
          if (s_ir && cnt == int'(SMAX)) gd = 1'b0;
`endif
          gi = !gd && s_ir;
          if (gd) begin
            cur_d = 1'b1; cur_we = s_dwe; cur_addr = s_da; cur_wd = s_dwd;
            cnt = s_ir ? cnt + 1 : 0; m_st = 1;
          end else if (gi) begin
            cur_d = 1'b0; cur_we = 1'b0; cur_addr = s_ia; cnt = 0; m_st = 1;
          end
        end
        1: if (s_rdy) begin
          m_st = 2;
          if (cur_d && cur_we) rmem[cur_addr[5:2]] = cur_wd;
          else if (cur_d)      e_dr = rmem[cur_addr[5:2]];
          else                 e_ir = rmem[cur_addr[5:2]];
        end
        default: m_st = 0;
      endcase
      checks++;
      if ({mem_req, if_ack, d_ack} !== {m_st == 1, m_st == 2 && !cur_d, m_st == 2 && cur_d}) begin
        failures++;
        $display("FAIL rnd_ctrl cyc=%0d req_iack_dack got=%0b exp=%0b", c,
                 {mem_req, if_ack, d_ack}, {m_st == 1, m_st == 2 && !cur_d, m_st == 2 && cur_d});
      end
      if (m_st == 1) begin
        checks++;
        if ({mem_we, mem_addr} !== {cur_we, cur_addr} || (cur_we && mem_wdata !== cur_wd)) begin
          failures++;
          $display("FAIL rnd_fields cyc=%0d got=%0h exp=%0h", c, {mem_we, mem_addr, mem_wdata},
                   {cur_we, cur_addr, cur_wd});
        end
      end
      checks++;
      if ({if_rdata, d_rdata} !== {e_ir, e_dr}) begin
        failures++;
        $display("FAIL rnd_rdata cyc=%0d got=%0h exp=%0h", c, {if_rdata, d_rdata}, {e_ir, e_dr});
      end
      // Requesters: hold while owning, may retarget while ungranted.
      ack_i = (m_st == 2) && !cur_d;
      ack_d = (m_st == 2) && cur_d;
      own_i = (m_st != 0) && !cur_d;
      own_d = (m_st != 0) && cur_d;
      if (if_req ? (ack_i || (!own_i && $urandom_range(0, 3) == 0)) : ($urandom_range(0, 2) == 0)) begin
        if_req = ack_i ? 1'($urandom_range(0, 1)) : 1'b1;
        a = $urandom; a[1:0] = 2'b00; if_addr = a;
      end
      if (d_req ? (ack_d || (!own_d && $urandom_range(0, 3) == 0)) : ($urandom_range(0, 2) == 0)) begin
        d_req = ack_d ? 1'($urandom_range(0, 1)) : 1'b1;
        a = $urandom; a[1:0] = 2'b00; d_addr = a;
        rv = $urandom_range(0, 1); d_we = rv[0]; d_wdata = $urandom;
      end
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = mem_req ? rmem[mem_addr[5:2]] : $urandom;
      s_ir = if_req; s_dr = d_req; s_dwe = d_we; s_rdy = mem_ready;
      s_ia = if_addr; s_da = d_addr; s_dwd = d_wdata;
    end
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_store();
    test_simultaneous();
    test_back_to_back();
    test_starvation();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
